cpu_mem_access_unit: RTL and testbench

- Parametrised load/store unit between the CPU sequencer (MEMR/MEMW) and the memory system.
- Accepts one request at a time over a valid/ready handshake and decodes the 16-bit CPU address into one of: SDRAM, bootloader ROM window, framebuffer window, or address-extension config registers.
- Returns exactly one response per accepted request.
- Adds what the inline MEMR/MEMW logic lacks: parametrised windows and widths, SDRAM busy back-pressure, a guaranteed single response, and an unmapped-access error flag.

---
 rtl/cpu_mem_pkg.sv | 34 +++
 rtl/cpu_mem_addr_decode.sv | 50 +++++
 rtl/cpu_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_cpu_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Brief    : Shared types and default memory-map constants for the CPU
//            load/store unit and its address decoder.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    typedef enum logic [2:0] {
        REG_RAM      = 3'd0,
        REG_ROM      = 3'd1,
        REG_FB       = 3'd2,
        REG_EXT      = 3'd3,
        REG_UNMAPPED = 3'd4
    } region_t;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RAM_ISSUE   = 3'd1,
        S_RAM_RD_WAIT = 3'd2,
        S_RAM_WR_HOLD = 3'd3,
        S_ROM_WAIT    = 3'd4,
        S_CFG         = 3'd5,
        S_RESP        = 3'd6
    } state_t;

    localparam logic [15:0] c_rom_base        = 16'hD000;
    localparam logic [15:0] c_fb_base         = 16'hE000;
    localparam logic [15:0] c_ext_kernel_addr = 16'h8004;
    localparam logic [15:0] c_ext_user_addr   = 16'h8800;

endpackage
`default_nettype wire

// File: rtl/cpu_mem_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_addr_decode
// Brief    : Combinational 16-bit CPU address to region/offset decoder.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_addr_decode
    import cpu_mem_pkg::*;
#(
    parameter logic [15:0] ROM_BASE        = c_rom_base,
    parameter int          ROM_DEPTH       = 2048,
    parameter logic [15:0] FB_BASE         = c_fb_base,
    parameter int          FB_DEPTH        = 4800,
    parameter logic [15:0] EXT_KERNEL_ADDR = c_ext_kernel_addr,
    parameter logic [15:0] EXT_USER_ADDR   = c_ext_user_addr,
    localparam int         ROM_AW          = $clog2(ROM_DEPTH),
    localparam int         FB_AW           = $clog2(FB_DEPTH)
) (
    input  logic [15:0]       i_addr,
    output region_t           o_region,
    output logic [ROM_AW-1:0] o_rom_off,
    output logic [FB_AW-1:0]  o_fb_off,
    output logic              o_ext_kernel_sel
);

    // Window ends computed one bit wider so a window touching 16'hFFFF cannot wrap.
    localparam logic [16:0] c_rom_end = 17'(ROM_BASE) + 17'(ROM_DEPTH);
    localparam logic [16:0] c_fb_end  = 17'(FB_BASE) + 17'(FB_DEPTH);

    logic [16:0] w_addr_x;

    always_comb begin
        w_addr_x         = {1'b0, i_addr};
        o_rom_off        = ROM_AW'(i_addr - ROM_BASE);
        o_fb_off         = FB_AW'(i_addr - FB_BASE);
        o_ext_kernel_sel = (i_addr == EXT_KERNEL_ADDR);
        if (!i_addr[15])
            o_region = REG_RAM;
        else if (w_addr_x >= {1'b0, ROM_BASE} && w_addr_x < c_rom_end)
            o_region = REG_ROM;
        else if (w_addr_x >= {1'b0, FB_BASE} && w_addr_x < c_fb_end)
            o_region = REG_FB;
        else if (i_addr == EXT_KERNEL_ADDR || i_addr == EXT_USER_ADDR)
            o_region = REG_EXT;
        else
            o_region = REG_UNMAPPED;
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_access_unit
// Brief    : Single-outstanding load/store unit routing CPU MEMR/MEMW to
//            SDRAM, boot ROM, framebuffer or extension registers.
//            Optional read timeout: CPU_MEM_ACCESS_UNIT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int          DATA_W          = 16,
    parameter int          EXT_W           = 5,
    parameter logic [15:0] ROM_BASE        = c_rom_base,
    parameter int          ROM_DEPTH       = 2048,
    parameter logic [15:0] FB_BASE         = c_fb_base,
    parameter int          FB_DEPTH        = 4800,
    parameter logic [15:0] EXT_KERNEL_ADDR = c_ext_kernel_addr,
    parameter logic [15:0] EXT_USER_ADDR   = c_ext_user_addr,
    parameter int          WR_HOLD         = 3,
    parameter int          TIMEOUT         = 1024,
    localparam int         RAM_AW          = 2*EXT_W+15,
    localparam int         ROM_AW          = $clog2(ROM_DEPTH),
    localparam int         FB_AW           = $clog2(FB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic              ram_busy,
    output logic              ram_rd_en,
    output logic [RAM_AW-1:0] ram_rd_addr,
    input  logic              ram_rd_ready,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr_en,
    output logic [RAM_AW-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [7:0]        fb_data,
    output logic [EXT_W-1:0]  ext_kernel,
    output logic [EXT_W-1:0]  ext_user
);

    localparam int c_hold_w = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    region_t             r_region;
    logic [ROM_AW-1:0]   r_rom_off;
    logic [FB_AW-1:0]    r_fb_off;
    logic                r_ext_kernel_sel;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [EXT_W-1:0]    r_ext_kernel;
    logic [EXT_W-1:0]    r_ext_user;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                w_hold_done;

    region_t             w_region;
    logic [ROM_AW-1:0]   w_rom_off;
    logic [FB_AW-1:0]    w_fb_off;
    logic                w_ext_kernel_sel;

    cpu_mem_addr_decode #(
        .ROM_BASE        (ROM_BASE),
        .ROM_DEPTH       (ROM_DEPTH),
        .FB_BASE         (FB_BASE),
        .FB_DEPTH        (FB_DEPTH),
        .EXT_KERNEL_ADDR (EXT_KERNEL_ADDR),
        .EXT_USER_ADDR   (EXT_USER_ADDR)
    ) u_decode (
        .i_addr           (req_addr),
        .o_region         (w_region),
        .o_rom_off        (w_rom_off),
        .o_fb_off         (w_fb_off),
        .o_ext_kernel_sel (w_ext_kernel_sel)
    );

    assign w_hold_done = (r_hold_cnt == c_hold_w'(WR_HOLD-1));

`ifdef CPU_MEM_ACCESS_UNIT_TIMEOUT_EN
    localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [c_to_w-1:0] r_to_cnt;
    logic              w_to_expired;

    assign w_to_expired = (r_to_cnt == c_to_w'(TIMEOUT-1));

    always_ff @(posedge clk) begin
        if (!rst_n || r_state != S_RAM_RD_WAIT)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + c_to_w'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    case (w_region)
                        REG_RAM: w_state_next = S_RAM_ISSUE;
                        REG_ROM: w_state_next = S_ROM_WAIT;
                        default: w_state_next = S_CFG;
                    endcase
                end
            end
            S_RAM_ISSUE: begin
                if (!ram_busy) begin
                    if (r_write)
                        w_state_next = S_RAM_WR_HOLD;
                    else if (ram_rd_ready)
                        w_state_next = S_RESP;
                    else
                        w_state_next = S_RAM_RD_WAIT;
                end
            end
            S_RAM_RD_WAIT: begin
                if (ram_rd_ready)
                    w_state_next = S_RESP;
`ifdef CPU_MEM_ACCESS_UNIT_TIMEOUT_EN
                else if (w_to_expired)
                    w_state_next = S_RESP;
`endif
            end
            S_RAM_WR_HOLD: if (w_hold_done) w_state_next = S_RESP;
            S_ROM_WAIT:    w_state_next = S_RESP;
            S_CFG:         w_state_next = S_RESP;
            S_RESP:        w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    // Request context is latched on accept; response data starts at zero so
    // FB reads, unmapped reads and ROM writes return 0 without extra cases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write          <= 1'b0;
            r_wdata          <= '0;
            r_region         <= REG_RAM;
            r_rom_off        <= '0;
            r_fb_off         <= '0;
            r_ext_kernel_sel <= 1'b0;
            r_ram_addr       <= '0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
            r_ext_kernel     <= '0;
            r_ext_user       <= '0;
            r_hold_cnt       <= '0;
        end else begin
            r_hold_cnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write          <= req_write;
                        r_wdata          <= req_wdata;
                        r_region         <= w_region;
                        r_rom_off        <= w_rom_off;
                        r_fb_off         <= w_fb_off;
                        r_ext_kernel_sel <= w_ext_kernel_sel;
                        r_ram_addr       <= {r_ext_kernel, r_ext_user, req_addr[14:0]};
                        r_rdata          <= '0;
                        r_err            <= 1'b0;
                    end
                end
                S_RAM_ISSUE: begin
                    if (!ram_busy && !r_write && ram_rd_ready)
                        r_rdata <= ram_rd_data;
                end
                S_RAM_RD_WAIT: begin
                    if (ram_rd_ready)
                        r_rdata <= ram_rd_data;
`ifdef CPU_MEM_ACCESS_UNIT_TIMEOUT_EN
                    else if (w_to_expired)
                        r_err <= 1'b1;
`endif
                end
                S_RAM_WR_HOLD: r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                S_ROM_WAIT: begin
                    if (!r_write)
                        r_rdata <= rom_data;
                end
                S_CFG: begin
                    case (r_region)
                        REG_EXT: begin
                            if (r_write) begin
                                if (r_ext_kernel_sel)
                                    r_ext_kernel <= r_wdata[EXT_W-1:0];
                                else
                                    r_ext_user <= r_wdata[EXT_W-1:0];
                            end else begin
                                r_rdata <= r_ext_kernel_sel ? DATA_W'(r_ext_kernel)
                                                            : DATA_W'(r_ext_user);
                            end
                        end
                        REG_UNMAPPED: r_err <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // ROM is synchronous, so its address follows the request while idle and
    // the word is ready to capture in ROM_WAIT.
    always_comb begin
        req_ready   = (r_state == S_IDLE);
        rsp_valid   = (r_state == S_RESP);
        rsp_rdata   = (r_state == S_RESP) ? r_rdata : '0;
        rsp_err     = (r_state == S_RESP) && r_err;
        ram_rd_en   = (r_state == S_RAM_ISSUE) && !ram_busy && !r_write;
        ram_wr_en   = (r_state == S_RAM_ISSUE) && !ram_busy && r_write;
        ram_rd_addr = r_ram_addr;
        ram_wr_addr = r_ram_addr;
        ram_wr_data = r_wdata;
        rom_addr    = (r_state == S_IDLE && req_valid) ? w_rom_off : r_rom_off;
        fb_we       = (r_state == S_CFG) && (r_region == REG_FB) && r_write;
        fb_addr     = r_fb_off;
        fb_data     = r_wdata[7:0];
        ext_kernel  = r_ext_kernel;
        ext_user    = r_ext_user;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_access_unit
// Brief    : Directed, table-driven self-checking bench for cpu_mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        ram_busy, ram_rd_en, ram_rd_ready, ram_wr_en;
    logic [24:0] ram_rd_addr, ram_wr_addr;
    logic [15:0] ram_rd_data, ram_wr_data;
    logic [10:0] rom_addr;
    logic [15:0] rom_data;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [7:0]  fb_data;
    logic [4:0]  ext_kernel, ext_user;

    int checks   = 0;
    int failures = 0;
    logic [4:0] prev_k = 5'd0;
    logic [4:0] prev_u = 5'd0;

    cpu_mem_access_unit #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_busy     (ram_busy),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_ready (ram_rd_ready),
        .ram_rd_data  (ram_rd_data),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .ext_kernel   (ext_kernel),
        .ext_user     (ext_user)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: word = 16'hA500 ^ address.
    always @(posedge clk) rom_data <= 16'hA500 ^ {5'b0, rom_addr};

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        exp_fb_we;
        logic [12:0] exp_fb_addr;
        logic [7:0]  exp_fb_data;
        logic        chk_rom;
        logic [10:0] exp_rom_addr;
        logic [4:0]  exp_k;
        logic [4:0]  exp_u;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fixed two-cycle transaction: accept, CFG/ROM_WAIT, RESP.
    task automatic run_vec(input vec_t v, input int idx);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1;
        chk($sformatf("v%0d_ready", idx), {31'b0, req_ready}, 32'd1);
        if (v.chk_rom)
            chk($sformatf("v%0d_rom_addr", idx), {21'b0, rom_addr}, {21'b0, v.exp_rom_addr});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk($sformatf("v%0d_mid_rsp", idx), {31'b0, rsp_valid}, 32'd0);
        chk($sformatf("v%0d_mid_ready", idx), {31'b0, req_ready}, 32'd0);
        chk($sformatf("v%0d_fb_we", idx), {31'b0, fb_we}, {31'b0, v.exp_fb_we});
        if (v.exp_fb_we) begin
            chk($sformatf("v%0d_fb_addr", idx), {19'b0, fb_addr}, {19'b0, v.exp_fb_addr});
            chk($sformatf("v%0d_fb_data", idx), {24'b0, fb_data}, {24'b0, v.exp_fb_data});
        end
        chk($sformatf("v%0d_mid_ext_k", idx), {27'b0, ext_kernel}, {27'b0, prev_k});
        tick();
        chk($sformatf("v%0d_rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
        chk($sformatf("v%0d_rdata", idx), {16'b0, rsp_rdata}, {16'b0, v.exp_rdata});
        chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_ext_k", idx), {27'b0, ext_kernel}, {27'b0, v.exp_k});
        chk($sformatf("v%0d_ext_u", idx), {27'b0, ext_user}, {27'b0, v.exp_u});
        tick();
        chk($sformatf("v%0d_post_rsp", idx), {31'b0, rsp_valid}, 32'd0);
        chk($sformatf("v%0d_post_ready", idx), {31'b0, req_ready}, 32'd1);
        prev_k = v.exp_k;
        prev_u = v.exp_u;
    endtask

    initial begin
        int n;
        //          wr    addr      wdata     rdata     err   fbwe  fbaddr    fbdata rom  romaddr  k      u
        vecs[0]  = '{1'b1, 16'h8004, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h00};
        vecs[1]  = '{1'b1, 16'h8800, 16'hFFE2, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[2]  = '{1'b0, 16'h8004, 16'h0000, 16'h001F, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[3]  = '{1'b0, 16'h8800, 16'h0000, 16'h0002, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[4]  = '{1'b0, 16'hD005, 16'h0000, 16'hA505, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 11'h005, 5'h1F, 5'h02};
        vecs[5]  = '{1'b0, 16'hD7FF, 16'h0000, 16'hA2FF, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 11'h7FF, 5'h1F, 5'h02};
        vecs[6]  = '{1'b0, 16'hD800, 16'h0000, 16'h0000, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[7]  = '{1'b1, 16'hE00A, 16'h12C3, 16'h0000, 1'b0, 1'b1, 13'h000A, 8'hC3, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[8]  = '{1'b1, 16'hF2BF, 16'h00AB, 16'h0000, 1'b0, 1'b1, 13'h12BF, 8'hAB, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[9]  = '{1'b1, 16'hF2C0, 16'h0077, 16'h0000, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[10] = '{1'b0, 16'hE00A, 16'h0000, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[11] = '{1'b0, 16'h9000, 16'h0000, 16'h0000, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[12] = '{1'b1, 16'hD005, 16'h1234, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 11'h005, 5'h1F, 5'h02};
        vecs[13] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[14] = '{1'b0, 16'h8005, 16'h0000, 16'h0000, 1'b1, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h1F, 5'h02};
        vecs[15] = '{1'b1, 16'h8004, 16'h0001, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h01, 5'h02};
        vecs[16] = '{1'b1, 16'h8800, 16'h0002, 16'h0000, 1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 11'h000, 5'h01, 5'h02};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        ram_busy = 1'b0; ram_rd_ready = 1'b0; ram_rd_data = 16'h0;
        repeat (3) tick();
        chk("rst_ready",     {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_strobes",   {29'b0, ram_rd_en, ram_wr_en, fb_we}, 32'd0);
        chk("rst_ram_addr",  {7'b0, ram_rd_addr}, 32'd0);
        chk("rst_rom_addr",  {21'b0, rom_addr}, 32'd0);
        chk("rst_fb_addr",   {19'b0, fb_addr}, 32'd0);
        chk("rst_ext",       {22'b0, ext_kernel, ext_user}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // RAM read with kernel=1, user=2; data returns several cycles later.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
        tick();
        req_valid = 1'b0;
        chk("rd_en",      {31'b0, ram_rd_en}, 32'd1);
        chk("rd_addr",    {7'b0, ram_rd_addr}, {7'b0, 5'd1, 5'd2, 15'h1234});
        chk("rd_ready0",  {31'b0, req_ready}, 32'd0);
        tick();
        chk("rd_en_pulse", {31'b0, ram_rd_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rd_wait%0d", i), {30'b0, rsp_valid, req_ready}, 32'd0);
        end
        ram_rd_ready = 1'b1; ram_rd_data = 16'hBEEF;
        tick();
        ram_rd_ready = 1'b0; ram_rd_data = 16'h0;
        chk("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd_rdata",     {16'b0, rsp_rdata}, 32'h0000BEEF);
        chk("rd_err",       {31'b0, rsp_err}, 32'd0);
        tick();
        chk("rd_done", {30'b0, rsp_valid, req_ready}, 32'd1);

        // Read data returned in the same cycle as the strobe.
        req_valid = 1'b1; req_addr = 16'h0001;
        tick();
        req_valid = 1'b0;
        chk("same_rd_en", {31'b0, ram_rd_en}, 32'd1);
        ram_rd_ready = 1'b1; ram_rd_data = 16'h1357;
        tick();
        ram_rd_ready = 1'b0;
        chk("same_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("same_rdata",     {16'b0, rsp_rdata}, 32'h00001357);
        tick();

        // Write under busy back-pressure; busy after issue must not matter.
        ram_busy = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'h55AA;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("busy_wr_en%0d", i), {31'b0, ram_wr_en}, 32'd0);
            chk($sformatf("busy_ready%0d", i), {31'b0, req_ready}, 32'd0);
        end
        ram_busy = 1'b0;
        #1;
        chk("wr_en",   {31'b0, ram_wr_en}, 32'd1);
        chk("wr_addr", {7'b0, ram_wr_addr}, {7'b0, 5'd1, 5'd2, 15'h0010});
        chk("wr_data", {16'b0, ram_wr_data}, 32'h000055AA);
        @(posedge clk); #1;
        ram_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold%0d", i), {29'b0, ram_wr_en, rsp_valid, req_ready}, 32'd0);
            tick();
        end
        chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("wr_rsp_err",   {31'b0, rsp_err}, 32'd0);
        ram_busy = 1'b0;
        tick();

        // Reset in RAM_RD_WAIT aborts the read; late data is ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0002;
        tick();
        req_valid = 1'b0;
        tick();
        chk("abort_wait", {30'b0, rsp_valid, ram_rd_en}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("abort_rsp",     {31'b0, rsp_valid}, 32'd0);
        chk("abort_strobes", {29'b0, ram_rd_en, ram_wr_en, fb_we}, 32'd0);
        chk("abort_ext",     {22'b0, ext_kernel, ext_user}, 32'd0);
        chk("abort_addr",    {7'b0, ram_rd_addr}, 32'd0);
        rst_n = 1'b1; ram_rd_ready = 1'b1; ram_rd_data = 16'hDEAD;
        tick();
        ram_rd_ready = 1'b0;
        chk("abort_late_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("abort_ready",    {31'b0, req_ready}, 32'd1);
        tick();
        chk("abort_idle", {30'b0, rsp_valid, req_ready}, 32'd1);

`ifdef CPU_MEM_ACCESS_UNIT_TIMEOUT_EN
        req_valid = 1'b1; req_addr = 16'h0003;
        tick();
        req_valid = 1'b0;
        tick();
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 32'd16);
        chk("to_rsp",    {31'b0, rsp_valid}, 32'd1);
        chk("to_err",    {31'b0, rsp_err}, 32'd1);
        chk("to_rdata",  {16'b0, rsp_rdata}, 32'd0);
        tick();
        ram_rd_ready = 1'b1; ram_rd_data = 16'h4321;
        tick();
        ram_rd_ready = 1'b0;
        chk("to_late_rsp", {30'b0, rsp_valid, req_ready}, 32'd1);
`else
        n = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
